// File: rtl/alu_control_sequencer_pkg.sv
// Shared types for the ALU control sequencer: FSM state encoding,
// opcode constants, opcode classes and the opcode -> ALU OP table.
package alu_control_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_MULDIV  = 2'd1,
        CLS_ILLEGAL = 2'd2
    } opclass_e;

    localparam logic [4:0] OPC_ADD = 5'd3;
    localparam logic [4:0] OPC_SUB = 5'd4;
    localparam logic [4:0] OPC_AND = 5'd5;
    localparam logic [4:0] OPC_OR  = 5'd6;
    localparam logic [4:0] OPC_SHR = 5'd7;
    localparam logic [4:0] OPC_SHL = 5'd9;
    localparam logic [4:0] OPC_ROR = 5'd10;
    localparam logic [4:0] OPC_ROL = 5'd11;
    localparam logic [4:0] OPC_MUL = 5'd15;
    localparam logic [4:0] OPC_DIV = 5'd16;
    localparam logic [4:0] OPC_NEG = 5'd17;
    localparam logic [4:0] OPC_NOT = 5'd18;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00100;
    localparam logic [4:0] ALU_SUB = 5'b00101;
    localparam logic [4:0] ALU_AND = 5'b00110;
    localparam logic [4:0] ALU_OR  = 5'b00111;
    localparam logic [4:0] ALU_SHR = 5'b01000;
    localparam logic [4:0] ALU_SHL = 5'b01010;
    localparam logic [4:0] ALU_ROR = 5'b01011;
    localparam logic [4:0] ALU_ROL = 5'b01100;
    localparam logic [4:0] ALU_MUL = 5'b10000;
    localparam logic [4:0] ALU_DIV = 5'b10001;
    localparam logic [4:0] ALU_NEG = 5'b10010;
    localparam logic [4:0] ALU_NOT = 5'b10011;

    // Unsupported opcodes map to ALU_NOP; they never reach T4 anyway.
    function automatic logic [4:0] alu_op_of(input logic [4:0] opc);
        logic [4:0] op;
        op = ALU_NOP;
        case (opc)
            OPC_ADD: op = ALU_ADD;
            OPC_SUB: op = ALU_SUB;
            OPC_AND: op = ALU_AND;
            OPC_OR:  op = ALU_OR;
            OPC_SHR: op = ALU_SHR;
            OPC_SHL: op = ALU_SHL;
            OPC_ROR: op = ALU_ROR;
            OPC_ROL: op = ALU_ROL;
            OPC_MUL: op = ALU_MUL;
            OPC_DIV: op = ALU_DIV;
            OPC_NEG: op = ALU_NEG;
            OPC_NOT: op = ALU_NOT;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

    function automatic opclass_e class_of(input logic [4:0] opc);
        opclass_e c;
        c = CLS_ILLEGAL;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL,
            OPC_NEG, OPC_NOT: c = CLS_ALU;
            OPC_MUL, OPC_DIV: c = CLS_MULDIV;
            default:          c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/alu_control_sequencer_instr_field_decoder.sv
// Instruction field decoder: turns ra/rb/rc into one-hot register
// selects, looks up the ALU OP and classifies the opcode.
// Ports: ir_hi_i (IR[31:15]) in; ra/rb/rc one-hot, op_o, cls_o out.
module instr_field_decoder
    import alu_control_sequencer_pkg::*;
(
    input  logic [31:15] ir_hi_i,
    output logic [15:0]  ra_oh_o,
    output logic [15:0]  rb_oh_o,
    output logic [15:0]  rc_oh_o,
    output logic [4:0]   op_o,
    output logic [1:0]   cls_o
);

    logic [4:0] opc;

    assign opc     = ir_hi_i[31:27];
    assign ra_oh_o = onehot16(ir_hi_i[26:23]);
    assign rb_oh_o = onehot16(ir_hi_i[22:19]);
    assign rc_oh_o = onehot16(ir_hi_i[18:15]);
    assign op_o    = alu_op_of(opc);
    assign cls_o   = class_of(opc);

endmodule

// File: rtl/alu_control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then execute (T3-T6) of
// register ALU and MUL/DIV instructions; outputs are datapath strobes,
// one-hot Rin/Rout, the ALU OP, plus Done / IllegalOp pulses.
module alu_control_sequencer
    import alu_control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic        MemReady,
    input  logic [31:0] IR,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowin,
    output logic        ZHighin,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  OP,
    output logic        Done,
    output logic        IllegalOp
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] ra_oh;
    logic [15:0] rb_oh;
    logic [15:0] rc_oh;
    logic [4:0]  alu_op;
    logic [1:0]  cls;
    logic        is_md;
    logic        is_ill;
    logic        unused_ir_lo;

    // Low IR bits carry immediates for other instruction formats.
    assign unused_ir_lo = ^IR[14:0];

    instr_field_decoder u_dec (
        .ir_hi_i (IR[31:15]),
        .ra_oh_o (ra_oh),
        .rb_oh_o (rb_oh),
        .rc_oh_o (rc_oh),
        .op_o    (alu_op),
        .cls_o   (cls)
    );

    assign is_md  = (cls == CLS_MULDIV);
    assign is_ill = (cls == CLS_ILLEGAL);

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        Rin       = 16'h0000;
        Rout      = 16'h0000;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZLowin    = 1'b0;
        ZHighin   = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        OP        = ALU_NOP;
        Done      = 1'b0;
        IllegalOp = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // Hold the read until memory answers; PCin only
                // on the completing cycle so the PC loads once.
                Read  = 1'b1;
                MDRin = 1'b1;
                if (MemReady) begin
                    PCin    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_ill) begin
                    IllegalOp = 1'b1;
                    state_d   = Run ? S_T0 : S_IDLE;
                end else begin
                    Rout    = rb_oh;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end
            end
            S_T4: begin
                Rout    = rc_oh;
                OP      = alu_op;
                ZLowin  = 1'b1;
                ZHighin = is_md;
                state_d = S_T5;
            end
            S_T5: begin
                ZLowout = 1'b1;
                if (is_md) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = ra_oh;
                    Done    = 1'b1;
                    state_d = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
                state_d  = Run ? S_T0 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_control_sequencer.md
ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

Interface
REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 Clear  input  1  reset, asynchronous, active-high.
REQ-003 Run  input  1  level; high starts or continues instruction fetch/execute.
REQ-004 MemReady  input  1  memory handshake; high means Mdatain is valid during a read.
REQ-005 IR  input  32  instruction register contents: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-006 Rin / Rout  output  16 each  one-hot register-file load/drive enables; bit n selects Rn.
REQ-007 PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin  output  1 each  datapath control strobes.
REQ-008 OP  output  5  ALU operation select.
REQ-009 Done  output  1  one-cycle pulse on the last cycle of a completed instruction.
REQ-010 IllegalOp  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6; all outputs decode from the registered state plus IR fields.
REQ-012 IDLE: all outputs 0; Run=1 -> T0, else stay.
REQ-013 T0: PCout=1, MARin=1, IncPC=1; -> T1.
REQ-014 T1: Read=1, MDRin=1 every cycle; while MemReady=0, stay in T1 with PCin=0; in the cycle MemReady=1, assert PCin=1 and go to T2, so PCin is asserted exactly once per instruction.
REQ-015 T2: MDRout=1, IRin=1; -> T3. IR is valid from T3 onward.
REQ-016 T3: if the opcode is unsupported, assert IllegalOp=1, assert no enables, and go to T0 if Run=1, else IDLE; otherwise assert Rout[rb]=1, Yin=1, and go to T4.
REQ-017 T4: Rout[rc]=1, OP=table(opcode), ZLowin=1; for MUL/DIV also ZHighin=1; -> T5.
REQ-018 T5 for ALU ops: ZLowout=1, Rin[ra]=1, Done=1, then go to T0 if Run=1, else IDLE.
REQ-019 T5 for MUL/DIV: ZLowout=1, LOin=1, no Rin, -> T6.
REQ-020 T6: ZHighout=1, HIin=1, Done=1, then go to T0 if Run=1, else IDLE.
REQ-021 OP SHALL be 5'b00000 in every state except T4.
REQ-022 At most one Rin bit and at most one Rout bit SHALL be high in any cycle; ra=0 is a legal destination (R0 is writable).
REQ-023 Run is sampled only in IDLE and on the final cycle of an instruction; deasserting Run mid-instruction does not abort it.
REQ-024 MemReady is ignored outside T1.

Reset
REQ-025 Clear=1 SHALL force state IDLE immediately, independent of Clock, with all outputs 0, including a reset taken mid-instruction or during a T1 wait.
REQ-026 The first rising edge after Clear falls SHALL evaluate IDLE transitions normally.

Structure
REQ-027 A shared package SHALL hold the state encoding, opcode constants (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT), and the opcode->ALU OP table.
REQ-028 One sub-module, instr_field_decoder, SHALL decode ra/rb/rc to one-hot 16-bit values and classify the opcode as ALU / MULDIV / illegal; the FSM lives in the top module.

Verification
REQ-029 Run=1, MemReady=1, IR=32'h20228000 (SUB R0,R4,R5) -> T0..T5 in 6 cycles; Rout=16'h0010 in T3; Rout=16'h0020 with OP=5'b00101 in T4; Rin=16'h0001 with Done=1 in T5.
REQ-030 MemReady held low for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles; PCin high only in the 4th cycle; IRin one cycle later.
REQ-031 MUL opcode with rb=R3, rc=R1 -> ZLowin and ZHighin in T4; LOin with no Rin in T5; HIin with Done in T6 (7 cycles total).
REQ-032 Undefined opcode 5'b11111 -> IllegalOp=1 in T3; no Rin/Yin/OP activity; next state T0 with Run=1.
REQ-033 Clear pulsed during T4 -> all outputs 0 before the next clock edge; restart from T0 after Clear drops with Run=1.
REQ-034 Run dropped during T2 of SUB -> instruction completes with Done; next state IDLE; outputs stay 0.
